// File: rtl/neuron_state_sequencer_if.sv
// Datapath-side bundle between the neuron state sequencer (master) and the shared
// LIF neuron datapath (slave).
interface neuron_state_sequencer_if #(
   parameter int unsigned N_STAGE = 2
);
   localparam int unsigned INPUTS = 2 ** N_STAGE;
   localparam int unsigned MW     = N_STAGE + 2;

   logic [INPUTS-1:0]    nrn_inputs;
   logic [INPUTS-1:0]    nrn_weights;
   logic signed [MW-1:0] nrn_last_membrane;
   logic                 nrn_was_spike;
   logic signed [MW-1:0] nrn_new_membrane;
   logic                 nrn_is_spike;

   modport master (
      output nrn_inputs,
      output nrn_weights,
      output nrn_last_membrane,
      output nrn_was_spike,
      input  nrn_new_membrane,
      input  nrn_is_spike
   );

   modport slave (
      input  nrn_inputs,
      input  nrn_weights,
      input  nrn_last_membrane,
      input  nrn_was_spike,
      output nrn_new_membrane,
      output nrn_is_spike
   );
endinterface

// File: rtl/neuron_state_sequencer.sv
// Owns weights, membranes and spike flags for a bank of LIF neurons and walks them
// through one shared datapath, one neuron per cycle, once per timestep.
module neuron_state_sequencer #(
   parameter int unsigned N_STAGE   = 2,
   parameter int unsigned N_NEURONS = 4,
   localparam int unsigned INPUTS   = 2 ** N_STAGE,
   localparam int unsigned IW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [INPUTS-1:0]              in_spikes,
   input  logic                           clear_state,
   input  logic                           w_we,
   input  logic [IW-1:0]                  w_addr,
   input  logic [INPUTS-1:0]              w_data,
   neuron_state_sequencer_if.master       nrn,
   output logic [N_NEURONS-1:0]           spikes,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned MW = N_STAGE + 2;
   localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

   typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [INPUTS-1:0]    weight_q [N_NEURONS];
   logic signed [MW-1:0] membrane_q [N_NEURONS];
   logic [N_NEURONS-1:0] flag_q;
   logic [INPUTS-1:0]    inputs_q;
   logic [N_NEURONS-1:0] spikes_q;
   logic                 busy_q, done_q;
   logic                 accept, do_clear, do_write, do_eval, do_publish;
   logic                 addr_ok;

   // Out-of-range write addresses only exist when N_NEURONS is not a power of two.
   if ((1 << IW) > N_NEURONS) begin : g_addr_chk
      assign addr_ok = (32'(w_addr) < N_NEURONS);
   end else begin : g_addr_all
      assign addr_ok = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      accept     = 1'b0;
      do_clear   = 1'b0;
      do_write   = 1'b0;
      do_eval    = 1'b0;
      do_publish = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               idx_d   = '0;
               state_d = StEval;
            end else if (clear_state) begin
               do_clear = 1'b1;
            end else if (w_we && addr_ok) begin
               do_write = 1'b1;
            end
         end
         StEval: begin
            do_eval = 1'b1;
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            do_publish = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // idx is parked at 0 outside EVAL, so IDLE/DONE naturally present neuron 0.
   assign nrn.nrn_inputs        = inputs_q;
   assign nrn.nrn_weights       = weight_q[idx_q];
   assign nrn.nrn_last_membrane = membrane_q[idx_q];
   assign nrn.nrn_was_spike     = flag_q[idx_q];

   assign spikes = spikes_q;
   assign busy   = busy_q;
   assign done   = done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         inputs_q <= '0;
         flag_q   <= '0;
         spikes_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            membrane_q[i] <= '0;
            weight_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= (state_d != StIdle);
         done_q  <= do_publish;
         if (accept) begin
            inputs_q <= in_spikes;
         end
         if (do_clear) begin
            flag_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
               membrane_q[i] <= '0;
            end
         end
         if (do_write) begin
            weight_q[w_addr] <= w_data;
         end
         if (do_eval) begin
            membrane_q[idx_q] <= nrn.nrn_new_membrane;
            flag_q[idx_q]     <= nrn.nrn_is_spike;
         end
         if (do_publish) begin
            spikes_q <= flag_q;
         end
      end
   end

endmodule

// File: doc/neuron_state_sequencer.md
Name: neuron_state_sequencer

Overview:
- Time-multiplexed state owner for a bank of N_NEURONS LIF neurons that share one `neuron` datapath.
- Per timestep it presents each neuron's stored weights, membrane and previous-spike flag to the datapath, one neuron per cycle.
- It writes back the datapath's new_membrane/is_spike results and publishes the resulting spike vector.
- It is the driver/consumer on the other side of the neuron's last_membrane/was_spike → new_membrane/is_spike interface.

Parameters:
N_STAGE, 2, neuron adder-tree depth; fan-in INPUTS = 2**N_STAGE; membrane width MW = N_STAGE+2 (signed)
N_NEURONS, 4, neurons sharing the datapath; index width IW = max(1, clog2(N_NEURONS))

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a timestep; sampled only in IDLE
in_spikes  in  INPUTS  input spike vector for the timestep; latched on accepted start
clear_state  in  1  zero all membranes and spike flags; honoured only in IDLE
w_we  in  1  weight write enable; honoured only in IDLE
w_addr  in  IW  neuron index for weight write
w_data  in  INPUTS  weight bits for that neuron
nrn_inputs  out  INPUTS  to datapath inputs: latched in_spikes
nrn_weights  out  INPUTS  to datapath weights: weight[idx]
nrn_last_membrane  out  MW  to datapath: membrane[idx]
nrn_was_spike  out  1  to datapath: spike_flag[idx]
nrn_new_membrane  in  MW  from datapath (combinational result)
nrn_is_spike  in  1  from datapath
spikes  out  N_NEURONS  spike vector of last completed timestep
busy  out  1  high in EVAL and DONE
done  out  1  one-cycle pulse when spikes is updated

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, idx=0, all membranes 0, spike flags 0, weights 0, latched inputs 0, spikes=0, busy=0, done=0. Reset mid-EVAL aborts the timestep; no partial spikes update.
- States: IDLE, EVAL, DONE.
- IDLE:
  - start=1 → latch in_spikes, idx←0, go to EVAL.
  - Else if clear_state=1 → all membranes and spike flags ←0.
  - Else if w_we=1 → weight[w_addr]←w_data.
  - Priority: start > clear_state > w_we, evaluated in the same cycle.
  - w_addr ≥ N_NEURONS: write dropped.
- EVAL: one neuron per cycle.
  - Datapath outputs are driven combinationally from idx.
  - At each posedge: membrane[idx]←nrn_new_membrane, spike_flag[idx]←nrn_is_spike.
  - If idx = N_NEURONS-1 → go to DONE, idx←0. Else idx←idx+1.
- DONE, one cycle:
  - spikes←spike_flag vector (bit i = neuron i), done=1.
  - Next state IDLE.
- busy is a registered output: 1 exactly in EVAL and DONE.
- Latency: start accepted at edge T; EVAL occupies edges T+1..T+N_NEURONS; done=1 and spikes valid in the cycle after edge T+N_NEURONS+1. A new start may be accepted the cycle done is high; it is sampled at the next edge, after the FSM returns to IDLE.
- Ignored while busy: start, clear_state and w_we are ignored entirely (not queued). in_spikes changes are invisible (latched copy used).
- spikes holds its value between done pulses; it never shows intermediate results.
- nrn_* outputs in IDLE/DONE present index 0 values; the datapath result is not written.
- Arithmetic: no arithmetic in this block; membranes are stored verbatim at full MW signed width. Saturation and reset-on-spike belong to the datapath.
- N_NEURONS=1: EVAL lasts one cycle.

Test Plan:
1. Reset, then start with in_spikes=4'b1111 and a stub datapath (new=last+1, is_spike=(new≥3)) → busy high 5 cycles; done pulses once at cycle 6 after start edge; spikes=4'b0000; all membranes=1.
2. Three more starts with the same stub → after third timestep membranes=3 and spikes=4'b1111; spikes stays unchanged between done pulses.
3. Weight load in IDLE w_addr=2, w_data=4'b1010, then start → nrn_weights=4'b1010 exactly in EVAL cycle idx=2, 0000 elsewhere; w_we asserted during EVAL with w_addr=0 → weight[0] unchanged.
4. start held high continuously → timesteps back-to-back with period N_NEURONS+2 cycles; no start accepted in EVAL/DONE; in_spikes toggled mid-EVAL → nrn_inputs constant within the timestep.
5. clear_state=1 and start=1 same IDLE cycle → timestep starts, membranes not cleared; clear_state alone → next timestep nrn_last_membrane=0 for all idx.
6. rst_n=0 at EVAL idx=2 → next cycle busy=0, done=0, spikes=0, membranes=0; subsequent start behaves as scenario 1.
